// File: rtl/sprite_pkg.sv
// Shared sprite constants and the in-flight lookup tag carried alongside ROM reads.
package sprite_pkg;

  localparam int unsigned SPRITE_W = 584;
  localparam int unsigned SPRITE_H = 167;
  localparam int unsigned COLOR_W  = 12;
  localparam int unsigned ROW_W    = 8;
  localparam int unsigned COL_W    = 10;

  localparam logic [COLOR_W-1:0] COLOR_BLACK = 12'h000;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                oob;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter; requesters flagged in prio_mask win outright (lowest index first)
// and are excluded from the rotation, so the pointer only advances on round-robin grants.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] prio_mask,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] prio_req;
  logic [NUM_REQ-1:0] rr_req;
  logic               rr_win;

  // Two passes over the rotation set: first indices at/above the pointer, then the wrap.
  always_comb begin
    prio_req  = req & prio_mask;
    rr_req    = req & ~prio_mask;
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    rr_win    = 1'b0;
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!gnt_valid && prio_req[k]) begin
          gnt_valid = 1'b1;
          gnt_id    = ID_W'(k);
          gnt[k]    = 1'b1;
        end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!gnt_valid && rr_req[k] && (k >= 32'(rr_ptr))) begin
          gnt_valid = 1'b1;
          rr_win    = 1'b1;
          gnt_id    = ID_W'(k);
          gnt[k]    = 1'b1;
        end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!gnt_valid && rr_req[k]) begin
          gnt_valid = 1'b1;
          rr_win    = 1'b1;
          gnt_id    = ID_W'(k);
          gnt[k]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (rr_win) begin
      rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered sprite colour ROM port among NUM_REQ requesters with tagged responses.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 (VGA scan-out) fixed top priority.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned IMG_W       = SPRITE_W,
  parameter int unsigned IMG_H       = SPRITE_H,
  parameter int unsigned ID_W        = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ROW_W-1:0] req_row,
  input  logic [NUM_REQ*COL_W-1:0] req_col,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [ROW_W-1:0]         rom_row,
  output logic [COL_W-1:0]         rom_col,
  input  logic [COLOR_W-1:0]       rom_color,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [COLOR_W-1:0]       rsp_color,
  output logic                     rsp_oob
);

  localparam int unsigned DEPTH = 1 + ROM_LATENCY;

  logic [NUM_REQ-1:0] prio_mask;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;
  logic [ROW_W-1:0]   sel_row;
  logic [COL_W-1:0]   sel_col;
  logic               sel_oob;
  tag_t               tag_pipe [DEPTH];
  tag_t               last_tag;

`ifdef SPRITE_ARB_PRIO0_EN
  assign prio_mask = NUM_REQ'(1);
`else
  assign prio_mask = '0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .prio_mask (prio_mask),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (xfer)
  );

  always_comb begin
    sel_row = '0;
    sel_col = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_row = req_row[k*ROW_W +: ROW_W];
        sel_col = req_col[k*COL_W +: COL_W];
      end
    end
    sel_oob = (32'(sel_row) >= IMG_H) || (32'(sel_col) >= IMG_W);
  end

  // The ROM is addressed even for out-of-range lookups; the tag masks the colour later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_row <= '0;
      rom_col <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      if (xfer) begin
        rom_row <= sel_row;
        rom_col <= sel_col;
      end
      tag_pipe[0] <= '{valid: xfer, id: TAG_ID_W'(gnt_id), oob: sel_oob};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign last_tag = tag_pipe[DEPTH-1];

  // The last tag stage lines up with valid ROM data; id/colour/oob hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_color <= '0;
      rsp_oob   <= 1'b0;
    end else begin
      rsp_valid <= last_tag.valid;
      if (last_tag.valid) begin
        rsp_id    <= ID_W'(last_tag.id);
        rsp_oob   <= last_tag.oob;
        rsp_color <= last_tag.oob ? COLOR_BLACK : rom_color;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed table, corner sequences, random traffic.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_row;
  logic [39:0] req_col;
  logic [3:0]  gnt;
  logic [7:0]  rom_row;
  logic [9:0]  rom_col;
  logic [11:0] rom_color;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_color;
  logic        rsp_oob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(
    .NUM_REQ     (4),
    .ROM_LATENCY (1),
    .IMG_W       (584),
    .IMG_H       (167),
    .ID_W        (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_row   (req_row),
    .req_col   (req_col),
    .gnt       (gnt),
    .rom_row   (rom_row),
    .rom_col   (rom_col),
    .rom_color (rom_color),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_color (rsp_color),
    .rsp_oob   (rsp_oob)
  );

  function automatic logic [11:0] rom_fn(input logic [7:0] r, input logic [9:0] c);
    return 12'(32'(r) * 37 + 32'(c) * 11 + 32'h5a5);
  endfunction

  // Registered ROM with one clock of latency.
  always @(posedge clk) rom_color <= rom_fn(rom_row, rom_col);

  typedef struct {
    int          due;
    int          id;
    bit          oob;
    logic [11:0] color;
  } exp_t;

  exp_t        pend[$];
  int          m_ptr = 0;
  int          cyc = 0;
  logic [7:0]  m_row = '0;
  logic [9:0]  m_col = '0;
  int          last_id = 0;
  logic [11:0] last_color = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r);
`ifdef SPRITE_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
`ifdef SPRITE_ARB_PRIO0_EN
      if (i != 0 && r[i]) return i;
`else
      if (r[i]) return i;
`endif
    end
    return -1;
  endfunction

  task automatic check_outputs();
    chk("rom_row", 32'(rom_row), 32'(m_row));
    chk("rom_col", 32'(rom_col), 32'(m_col));
    if (pend.size() > 0 && pend[0].due == cyc) begin
      chk("rsp_valid", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), pend[0].id);
      chk("rsp_oob", 32'(rsp_oob), 32'(pend[0].oob));
      chk("rsp_color", 32'(rsp_color), 32'(pend[0].color));
      last_id    = pend[0].id;
      last_color = pend[0].color;
      pend.delete(0);
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 0);
      chk("rsp_id_hold", 32'(rsp_id), last_id);
      chk("rsp_color_hold", 32'(rsp_color), 32'(last_color));
    end
  endtask

  // Called just after a falling edge; returns the model grant and the observed gnt.
  task automatic step(input logic [3:0] r, input logic [31:0] rows, input logic [39:0] cols,
                      input bit use_tbl, input bit tbl_oob, output int g, output logic [3:0] gobs);
    logic [7:0] gr;
    logic [9:0] gc;
    bit         oob;
    req = r; req_row = rows; req_col = cols;
    #1;
    g    = model_pick(r);
    gobs = gnt;
    chk("gnt", 32'(gnt), (g < 0) ? 0 : (1 << g));
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      gr  = rows[g*8 +: 8];
      gc  = cols[g*10 +: 10];
      oob = use_tbl ? tbl_oob : (gr >= 8'd167 || gc >= 10'd584);
      pend.push_back('{due: cyc + 2, id: g, oob: oob, color: oob ? 12'h000 : rom_fn(gr, gc)});
      m_row = gr;
      m_col = gc;
`ifdef SPRITE_ARB_PRIO0_EN
      if (g != 0) m_ptr = (g + 1) % 4;
`else
      m_ptr = (g + 1) % 4;
`endif
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_rom_row"}, 32'(rom_row), 0);
    chk({tag, "_rom_col"}, 32'(rom_col), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_color"}, 32'(rsp_color), 0);
    chk({tag, "_rsp_oob"}, 32'(rsp_oob), 0);
  endtask

  task automatic apply_reset(input int ncyc);
    reset = 1'b1;
    req   = 4'hf;
    #1;
    check_zero("reset");
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    check_zero("reset_hold");
    reset = 1'b0;
    req   = '0;
    pend.delete();
    m_ptr = 0; m_row = '0; m_col = '0; last_id = 0; last_color = '0;
  endtask

  typedef struct {
    logic [3:0] rq;
    logic [7:0] row;
    logic [9:0] col;
    logic [3:0] gnt;
    bit         oob;
  } vec_t;

  vec_t        tbl[10];
  int          g;
  logic [3:0]  gobs;
  logic [3:0]  r;
  logic [31:0] rows;
  logic [39:0] cols;
  bit          act[4];
  logic [7:0]  arow[4];
  logic [9:0]  acol[4];
  int          waitc[4];

  initial begin
    reset = 1'b0; req = '0; req_row = '0; req_col = '0;
    #2;
    apply_reset(2);

    // Same address on every lane; expectations hold for both arbitration modes.
    tbl[0] = '{4'b0001, 8'd81,  10'd0,    4'b0001, 1'b0};
    tbl[1] = '{4'b0001, 8'd167, 10'd0,    4'b0001, 1'b1};
    tbl[2] = '{4'b0001, 8'd0,   10'd584,  4'b0001, 1'b1};
    tbl[3] = '{4'b0001, 8'd166, 10'd583,  4'b0001, 1'b0};
    tbl[4] = '{4'b0000, 8'd5,   10'd5,    4'b0000, 1'b0};
    tbl[5] = '{4'b1010, 8'd10,  10'd10,   4'b0010, 1'b0};
    tbl[6] = '{4'b1010, 8'd255, 10'd5,    4'b1000, 1'b1};
    tbl[7] = '{4'b1111, 8'd0,   10'd1023, 4'b0001, 1'b1};
    tbl[8] = '{4'b1110, 8'd100, 10'd100,  4'b0010, 1'b0};
    tbl[9] = '{4'b0100, 8'd166, 10'd0,    4'b0100, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rq, {4{tbl[i].row}}, {4{tbl[i].col}}, 1'b1, tbl[i].oob, g, gobs);
      chk("tbl_gnt", 32'(gobs), 32'(tbl[i].gnt));
    end
    repeat (3) step(4'b0000, '0, '0, 1'b0, 1'b0, g, gobs);

    // Contention from a fresh pointer.
    apply_reset(1);
    for (int i = 0; i < 8; i++) begin
      rows = $urandom; cols = {$urandom, 8'($urandom)};
      step(4'b1111, rows, cols, 1'b0, 1'b0, g, gobs);
`ifdef SPRITE_ARB_PRIO0_EN
      chk("contention_order", 32'(gobs), 1);
`else
      chk("contention_order", 32'(gobs), 1 << (i % 4));
`endif
    end
`ifdef SPRITE_ARB_PRIO0_EN
    for (int i = 0; i < 4; i++) begin
      step(4'b1110, 32'h0a0b0c0d, 40'h0102030405, 1'b0, 1'b0, g, gobs);
      chk("prio_drop_order", 32'(gobs), 1 << ((i % 3) + 1));
    end
`endif
    repeat (3) step(4'b0000, '0, '0, 1'b0, 1'b0, g, gobs);

    // Sparse: requester 3 held, requester 1 pulsed every third clock.
    for (int i = 0; i < 12; i++) begin
      r = {1'b1, 1'b0, (i % 3 == 0), 1'b0};
      step(r, 32'h21222324, 40'h1111111111, 1'b0, 1'b0, g, gobs);
    end
    repeat (3) step(4'b0000, '0, '0, 1'b0, 1'b0, g, gobs);

    // Reset with two lookups in flight: neither may respond afterwards.
    apply_reset(1);
    step(4'b0001, 32'h00000010, 40'h0000000020, 1'b0, 1'b0, g, gobs);
    step(4'b0010, 32'h00001100, 40'h0000008800, 1'b0, 1'b0, g, gobs);
    apply_reset(2);
    repeat (4) step(4'b0000, '0, '0, 1'b0, 1'b0, g, gobs);

    // Random traffic honouring the hold-until-grant handshake.
    for (int i = 0; i < 4; i++) begin act[i] = 0; waitc[i] = 0; arow[i] = '0; acol[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (act[i] && $urandom_range(0, 15) == 0) begin
          act[i] = 0; waitc[i] = 0;
        end else if (!act[i] && $urandom_range(0, 1) == 1) begin
          act[i] = 1; waitc[i] = 0;
          arow[i] = 8'($urandom_range(0, 255));
          acol[i] = 10'($urandom_range(0, 700));
        end
        r[i] = act[i];
        rows[i*8 +: 8]   = arow[i];
        cols[i*10 +: 10] = acol[i];
      end
      step(r, rows, cols, 1'b0, 1'b0, g, gobs);
      for (int i = 0; i < 4; i++) begin
        if (act[i]) begin
          if (g == i) begin
`ifndef SPRITE_ARB_PRIO0_EN
            chk("fair_wait", 32'(waitc[i] <= 3), 1);
`endif
            act[i] = 0;
          end else begin
            waitc[i]++;
          end
        end
      end
    end
    repeat (4) step(4'b0000, '0, '0, 1'b0, 1'b0, g, gobs);
    chk("drain_empty", 32'(pend.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
